// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// No logic; holds FSM encoding, IF/ID record layout and instruction field positions.
// Optional skid buffer is enabled by defining FETCH_SKID_BUFFER_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [5:0] OPCODE_RTYPE = 6'b000000;

    // Instruction field bit positions (MIPS-style encoding)
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds one fetched instruction plus its valid flag.
// Latency: one cycle from load to visible contents.
// Backpressure: contents hold until consumed; flush beats load beats consume.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   flush,
    input  logic   consume,
    input  if_id_t load_dat,
    output logic   ifid_vld,
    output if_id_t ifid_dat
);

    // Valid/data update: a redirect kills the entry, a load refills it, a consume empties it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifid_vld <= 1'b0;
            ifid_dat <= '0;
        end else if (flush) begin
            ifid_vld <= 1'b0;
        end else if (load) begin
            ifid_vld <= 1'b1;
            ifid_dat <= load_dat;
        end else if (consume) begin
            ifid_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, memory request FSM, IF/ID register and register-file address decode.
// Latency: request issued the cycle after entering REQ; response lands in IF/ID on the next edge.
// Backpressure: DecReady low with IF/ID full stalls fetch; FETCH_SKID_BUFFER_EN adds a one-entry skid.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] IMemAddr,
    output logic        IMemReq,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    input  logic        BrTaken,
    input  logic [31:0] BrTarget,
    input  logic        DecReady,
    output logic        IfIdValid,
    output logic [31:0] IfIdInstr,
    output logic [31:0] IfIdPC4,
    output logic [4:0]  ARead1,
    output logic [4:0]  ARead2,
    output logic [4:0]  AWR
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt, pc_inc;
    logic         ifid_load, ifid_flush;
    logic         stall;
    if_id_t       load_dat, ifid_dat;

    assign pc_inc   = pc + PC_STEP;
    assign stall    = IfIdValid && !DecReady;
    assign IMemAddr = pc;

`ifdef FETCH_SKID_BUFFER_EN
    logic   skid_vld, skid_set, skid_clr;
    if_id_t skid_dat;

    // A response that cannot enter IF/ID can park in the skid, so keep requesting
    assign IMemReq = (state == REQ);

    // Skid entry: filled by a response arriving while IF/ID is blocked, drained on DecReady or redirect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_vld <= 1'b0;
            skid_dat <= '0;
        end else if (skid_clr) begin
            skid_vld <= 1'b0;
        end else if (skid_set) begin
            skid_vld <= 1'b1;
            skid_dat <= '{instr: IMemData, pc4: pc_inc};
        end
    end
`else
    // Without a skid, never issue a request whose response would have nowhere to go
    assign IMemReq = (state == REQ) && !stall;
`endif

    // State and PC registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Next state, PC update and IF/ID control; redirects always win over capture
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        load_dat   = '{instr: IMemData, pc4: pc_inc};
`ifdef FETCH_SKID_BUFFER_EN
        skid_set   = 1'b0;
        skid_clr   = 1'b0;
`endif
        case (state)
            IDLE: begin
                state_nxt = REQ;
                if (BrTaken) begin
                    pc_nxt     = BrTarget;
                    ifid_flush = 1'b1;
                end
            end
            REQ: begin
                if (BrTaken) begin
                    pc_nxt     = BrTarget;
                    ifid_flush = 1'b1;
                    // An issued request still owes a response that must be thrown away
                    state_nxt  = (IMemReq && !IMemAck) ? DROP : REQ;
                end else if (IMemReq && IMemAck) begin
                    pc_nxt = pc_inc;
`ifdef FETCH_SKID_BUFFER_EN
                    if (stall) begin
                        skid_set  = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        ifid_load = 1'b1;
                    end
`else
                    ifid_load = 1'b1;
`endif
                end
`ifndef FETCH_SKID_BUFFER_EN
                else if (stall) begin
                    state_nxt = HOLD;
                end
`endif
            end
            HOLD: begin
                if (BrTaken) begin
                    pc_nxt     = BrTarget;
                    ifid_flush = 1'b1;
                    state_nxt  = REQ;
`ifdef FETCH_SKID_BUFFER_EN
                    skid_clr   = 1'b1;
`endif
                end else if (DecReady) begin
                    state_nxt = REQ;
`ifdef FETCH_SKID_BUFFER_EN
                    ifid_load = skid_vld;
                    load_dat  = skid_dat;
                    skid_clr  = 1'b1;
`endif
                end
            end
            DROP: begin
                if (BrTaken) begin
                    pc_nxt     = BrTarget;
                    ifid_flush = 1'b1;
                end
                if (IMemAck) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ifid_load),
        .flush    (ifid_flush),
        .consume  (DecReady),
        .load_dat (load_dat),
        .ifid_vld (IfIdValid),
        .ifid_dat (ifid_dat)
    );

    assign IfIdInstr = ifid_dat.instr;
    assign IfIdPC4   = ifid_dat.pc4;

    // Register-file addresses: R-type writes rd, everything else writes rt
    assign ARead1 = IfIdInstr[RS_MSB:RS_LSB];
    assign ARead2 = IfIdInstr[RT_MSB:RT_LSB];
    assign AWR    = (IfIdInstr[OP_MSB:OP_LSB] == OPCODE_RTYPE) ? IfIdInstr[RD_MSB:RD_LSB]
                                                               : IfIdInstr[RT_MSB:RT_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage (default build, no skid buffer).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
// Every scenario task checks its own expected values inline.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] IMemAddr;
    logic        IMemReq;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic        BrTaken;
    logic [31:0] BrTarget;
    logic        DecReady;
    logic        IfIdValid;
    logic [31:0] IfIdInstr;
    logic [31:0] IfIdPC4;
    logic [4:0]  ARead1, ARead2, AWR;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .IMemAddr  (IMemAddr),
        .IMemReq   (IMemReq),
        .IMemAck   (IMemAck),
        .IMemData  (IMemData),
        .BrTaken   (BrTaken),
        .BrTarget  (BrTarget),
        .DecReady  (DecReady),
        .IfIdValid (IfIdValid),
        .IfIdInstr (IfIdInstr),
        .IfIdPC4   (IfIdPC4),
        .ARead1    (ARead1),
        .ARead2    (ARead2),
        .AWR       (AWR)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Request issued this cycle: answer it next cycle, then step past the capture edge
    task automatic ack_next(input logic [31:0] data);
        cyc();
        IMemAck  = 1'b1;
        IMemData = data;
        cyc();
        IMemAck  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; BrTaken = 1'b0; BrTarget = '0; IMemAck = 1'b0; IMemData = '0; DecReady = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; BrTaken = 1'b0; BrTarget = '0; IMemAck = 1'b0; IMemData = '0; DecReady = 1'b1;
        cyc();
        cyc();
        checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", IMemReq); end
        checks++; if (IMemAddr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 00000000", IMemAddr); end
        checks++; if (IfIdValid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", IfIdValid); end
        checks++; if (IfIdInstr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 00000000", IfIdInstr); end
        checks++; if (IfIdPC4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h exp 00000000", IfIdPC4); end
        rst_n = 1'b1;
        #1;
        checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL idle_req got %b exp 0", IMemReq); end
    endtask

    // Continues straight from test_reset (state IDLE)
    task automatic test_sequential();
        cyc();
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin errors++; $display("FAIL seq_req0 got %b/%h exp 1/00000000", IMemReq, IMemAddr); end
        cyc();
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0 || IfIdValid !== 1'b0) begin errors++; $display("FAIL seq_hold0 got %b/%h/%b exp 1/00000000/0", IMemReq, IMemAddr, IfIdValid); end
        IMemAck = 1'b1; IMemData = 32'h012A_4020;
        cyc();
        IMemAck = 1'b0;
        checks++; if (IfIdValid !== 1'b1 || IfIdInstr !== 32'h012A_4020) begin errors++; $display("FAIL seq_cap0 got %b/%h exp 1/012a4020", IfIdValid, IfIdInstr); end
        checks++; if (IfIdPC4 !== 32'h4) begin errors++; $display("FAIL seq_pc4_0 got %h exp 00000004", IfIdPC4); end
        checks++; if (IMemAddr !== 32'h4) begin errors++; $display("FAIL seq_addr1 got %h exp 00000004", IMemAddr); end
        checks++; if (ARead1 !== 5'd9 || ARead2 !== 5'd10 || AWR !== 5'd8) begin errors++; $display("FAIL dec_add got %0d/%0d/%0d exp 9/10/8", ARead1, ARead2, AWR); end
        ack_next(32'h8D28_0004);
        checks++; if (IfIdPC4 !== 32'h8 || IMemAddr !== 32'h8) begin errors++; $display("FAIL seq_pc4_1 got %h/%h exp 00000008/00000008", IfIdPC4, IMemAddr); end
        checks++; if (ARead1 !== 5'd9 || ARead2 !== 5'd8 || AWR !== 5'd8) begin errors++; $display("FAIL dec_lw got %0d/%0d/%0d exp 9/8/8", ARead1, ARead2, AWR); end
        ack_next(32'h3C01_1234);
        checks++; if (IfIdPC4 !== 32'hC || IMemAddr !== 32'hC || IfIdInstr !== 32'h3C01_1234) begin errors++; $display("FAIL seq_pc4_2 got %h/%h/%h exp 0000000c/0000000c/3c011234", IfIdPC4, IMemAddr, IfIdInstr); end
    endtask

    task automatic test_stall();
        int extra;
        extra = 0;
        do_reset();
        cyc();
        ack_next(32'h1111_0000);
        checks++; if (IfIdValid !== 1'b1 || IfIdPC4 !== 32'h4) begin errors++; $display("FAIL stall_fill got %b/%h exp 1/00000004", IfIdValid, IfIdPC4); end
        DecReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (IMemReq === 1'b1) extra++;
            checks++; if (IfIdValid !== 1'b1 || IfIdInstr !== 32'h1111_0000) begin errors++; $display("FAIL stall_hold%0d got %b/%h exp 1/11110000", i, IfIdValid, IfIdInstr); end
            cyc();
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL stall_extra got %0d exp 0", extra); end
        DecReady = 1'b1;
        cyc();
        checks++; if (IfIdValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 32'h4) begin errors++; $display("FAIL stall_resume got %b/%b/%h exp 0/1/00000004", IfIdValid, IMemReq, IMemAddr); end
        ack_next(32'h2222_0004);
        checks++; if (IfIdValid !== 1'b1 || IfIdInstr !== 32'h2222_0004 || IfIdPC4 !== 32'h8) begin errors++; $display("FAIL stall_next got %b/%h/%h exp 1/22220004/00000008", IfIdValid, IfIdInstr, IfIdPC4); end
    endtask

    task automatic test_branch_drop();
        do_reset();
        cyc();
        cyc();
        BrTaken = 1'b1; BrTarget = 32'h0000_0100;
        cyc();
        BrTaken = 1'b0;
        #1;
        checks++; if (IMemReq !== 1'b0 || IfIdValid !== 1'b0) begin errors++; $display("FAIL drop_wait got %b/%b exp 0/0", IMemReq, IfIdValid); end
        cyc();
        IMemAck = 1'b1; IMemData = 32'hDEAD_BEEF;
        #1;
        checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL drop_ack_req got %b exp 0", IMemReq); end
        cyc();
        IMemAck = 1'b0;
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h100 || IfIdValid !== 1'b0) begin errors++; $display("FAIL drop_redirect got %b/%h/%b exp 1/00000100/0", IMemReq, IMemAddr, IfIdValid); end
        ack_next(32'h3333_0100);
        checks++; if (IfIdValid !== 1'b1 || IfIdInstr !== 32'h3333_0100 || IfIdPC4 !== 32'h104) begin errors++; $display("FAIL drop_target got %b/%h/%h exp 1/33330100/00000104", IfIdValid, IfIdInstr, IfIdPC4); end
    endtask

    task automatic test_branch_ack();
        do_reset();
        cyc();
        ack_next(32'h1234_0000);
        cyc();
        DecReady = 1'b0; BrTaken = 1'b1; BrTarget = 32'h0000_0200; IMemAck = 1'b1; IMemData = 32'h7777_0004;
        cyc();
        BrTaken = 1'b0; IMemAck = 1'b0;
        checks++; if (IfIdValid !== 1'b0 || IMemAddr !== 32'h200 || IMemReq !== 1'b1) begin errors++; $display("FAIL brack_flush got %b/%h/%b exp 0/00000200/1", IfIdValid, IMemAddr, IMemReq); end
        ack_next(32'h4444_0200);
        checks++; if (IfIdValid !== 1'b1 || IfIdInstr !== 32'h4444_0200 || IfIdPC4 !== 32'h204) begin errors++; $display("FAIL brack_target got %b/%h/%h exp 1/44440200/00000204", IfIdValid, IfIdInstr, IfIdPC4); end
        checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL brack_stall_req got %b exp 0", IMemReq); end
    endtask

    // Continues from test_branch_ack: IF/ID full, request about to issue
    task automatic test_reset_wrap();
        DecReady = 1'b1;
        cyc();
        rst_n = 1'b0;
        cyc();
        checks++; if (IMemReq !== 1'b0 || IfIdValid !== 1'b0 || IMemAddr !== 32'h0) begin errors++; $display("FAIL midrst got %b/%b/%h exp 0/0/00000000", IMemReq, IfIdValid, IMemAddr); end
        cyc();
        rst_n = 1'b1; IMemAck = 1'b1; IMemData = 32'hBAD0_BAD0; BrTaken = 1'b1; BrTarget = 32'hFFFF_FFFC;
        cyc();
        IMemAck = 1'b0; BrTaken = 1'b0;
        checks++; if (IfIdValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got %b/%b/%h exp 0/1/fffffffc", IfIdValid, IMemReq, IMemAddr); end
        ack_next(32'h5555_FFFC);
        checks++; if (IfIdValid !== 1'b1 || IfIdInstr !== 32'h5555_FFFC || IfIdPC4 !== 32'h0) begin errors++; $display("FAIL wrap_cap got %b/%h/%h exp 1/5555fffc/00000000", IfIdValid, IfIdInstr, IfIdPC4); end
        checks++; if (IMemAddr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 00000000", IMemAddr); end
        ack_next(32'h6666_0000);
        checks++; if (IfIdPC4 !== 32'h4 || IMemAddr !== 32'h4) begin errors++; $display("FAIL wrap_next got %h/%h exp 00000004/00000004", IfIdPC4, IMemAddr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_drop();
        test_branch_ack();
        test_reset_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
